// File: rtl/weight_load_sequencer.sv
// ============================================================================
// weight_load_sequencer
//   Streams filter rows from weight memory into a systolic array, round by
//   round, and holds ready until the array acknowledges each round.
//   Optional macro: WEIGHT_SEQ_STALL_CNT_EN (enables the WAIT stall counter).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module weight_load_sequencer #(
    parameter int N_ROWS_ARRAY = 16,
    parameter int N            = 3,
    parameter int ADDR_WIDTH   = 16,
    parameter int ROUND_WIDTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rd_weight_rst,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [$clog2(N+1)-1:0]  filter_size_i,
    input  logic [ROUND_WIDTH-1:0]  num_rounds_i,
    input  logic                    array_ack_i,
    output logic [ADDR_WIDTH-1:0]   weight_rd_addr_o,
    output logic                    rd_weight_ld_o,
    output logic                    load_o,
    output logic                    ready_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [ROUND_WIDTH-1:0]  round_o,
    output logic [15:0]             stall_cnt_o
);

    localparam int FW = $clog2(N+1);

    if (N < 1 || N_ROWS_ARRAY < 1 || ROUND_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_param_check
        $error("weight_load_sequencer: invalid parameterisation");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [FW-1:0]          r_fsize;
    logic [FW-1:0]          r_k;
    logic [ROUND_WIDTH-1:0] r_nrounds;
    logic [ROUND_WIDTH-1:0] r_round;
    logic                   r_load;
    logic                   r_err;
    logic                   w_cfg_ok;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_advance;

    assign w_cfg_ok = (filter_size_i != '0) && (filter_size_i <= FW'(N)) &&
                      (num_rounds_i != '0);

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        rd_weight_ld_o = 1'b0;
        ready_o        = 1'b0;
        busy_o         = 1'b1;
        done_o         = 1'b0;
        w_accept       = 1'b0;
        w_reject       = 1'b0;
        w_advance      = 1'b0;
        case (r_state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    if (w_cfg_ok) begin
                        w_accept = 1'b1;
                        w_next   = LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            LOAD: begin
                rd_weight_ld_o = 1'b1;
                if (r_k == r_fsize - FW'(1)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: w_next = WAIT;
            WAIT: begin
                ready_o = 1'b1;
                if (array_ack_i) begin
                    if (r_round == r_nrounds - ROUND_WIDTH'(1)) begin
                        w_next = DONE;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = LOAD;
                    end
                end
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Rows are contiguous across rounds, so a running pointer equals
    // base + round*filter_size + k without a multiplier.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            r_addr    <= '0;
            r_fsize   <= '0;
            r_k       <= '0;
            r_nrounds <= '0;
            r_round   <= '0;
            r_load    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_load <= rd_weight_ld_o;
            r_err  <= w_reject;
            if (w_accept) begin
                r_addr    <= base_addr_i;
                r_fsize   <= filter_size_i;
                r_nrounds <= num_rounds_i;
                r_round   <= '0;
                r_k       <= '0;
            end else if (rd_weight_ld_o) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                r_k    <= r_k + FW'(1);
            end else if (w_advance) begin
                r_round <= r_round + ROUND_WIDTH'(1);
                r_k     <= '0;
            end
        end
    end

    assign weight_rd_addr_o = rd_weight_ld_o ? r_addr : '0;
    assign load_o           = r_load;
    assign err_o            = r_err;
    assign round_o          = r_round;

`ifdef WEIGHT_SEQ_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            r_stall <= '0;
        end else if (w_accept) begin
            r_stall <= '0;
        end else if (r_state == WAIT && !array_ack_i && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule

`default_nettype wire
